// File: rtl/rx_shift_register.sv
// Receive-side SPI shifter: samples miso on sample_en strobes, assembles a char_len-bit word.
// Optional word-loss detection (rx_ack/rx_overrun) is built when SPI_RX_OVERRUN_EN is defined.
module rx_shift_register #(
  parameter int unsigned MAX_LEN = 128
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       go_busy,
  input  logic                       sample_en,
  input  logic                       miso,
  input  logic                       lsb,
  input  logic [$clog2(MAX_LEN)-1:0] char_len,
  output logic [MAX_LEN-1:0]         rx_data,
`ifdef SPI_RX_OVERRUN_EN
  input  logic                       rx_ack,
  output logic                       rx_overrun,
`endif
  output logic                       rx_valid,
  output logic                       rx_busy
);

  localparam int unsigned CW = $clog2(MAX_LEN);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      lenm1_q, lenm1_d;
  logic               lsb_q, lsb_d;
  logic [CW:0]        count_q, count_d;
  logic [MAX_LEN-1:0] shreg_q, shreg_d;
  logic [MAX_LEN-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rx_busy_q, rx_busy_d;

  logic start, sample, complete;

  assign start    = (state_q == IDLE) && go_busy;
  assign sample   = (state_q == SHIFT) && go_busy && sample_en;
  assign complete = sample && (count_q == (CW+1)'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (go_busy) state_d = SHIFT;
      SHIFT: begin
        if (!go_busy)      state_d = IDLE;
        else if (complete) state_d = DONE;
      end
      DONE:    if (!go_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lenm1_d    = lenm1_q;
    lsb_d      = lsb_q;
    count_d    = count_q;
    shreg_d    = shreg_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_busy_d  = (state_d == SHIFT);
    if (start) begin
      // char_len-1 wraps 0 -> MAX_LEN-1, which is exactly the top insert position
      lenm1_d = char_len - CW'(1);
      lsb_d   = lsb;
      shreg_d = '0;
      count_d = (char_len == '0) ? (CW+1)'(MAX_LEN) : {1'b0, char_len};
    end
    if (sample) begin
      if (lsb_q) shreg_d = (shreg_q >> 1) | (MAX_LEN'(miso) << lenm1_q);
      else       shreg_d = {shreg_q[MAX_LEN-2:0], miso};
      count_d = count_q - (CW+1)'(1);
    end
    if (complete) begin
      rx_data_d  = shreg_d;
      rx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lenm1_q    <= '0;
      lsb_q      <= 1'b0;
      count_q    <= '0;
      shreg_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_busy_q  <= 1'b0;
    end else begin
      lenm1_q    <= lenm1_d;
      lsb_q      <= lsb_d;
      count_q    <= count_d;
      shreg_q    <= shreg_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_busy_q  <= rx_busy_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign rx_busy  = rx_busy_q;

`ifdef SPI_RX_OVERRUN_EN
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;

  // A completion coinciding with rx_ack consumes the old word and leaves the new one pending
  always_comb begin
    pending_d = pending_q;
    if (complete)    pending_d = 1'b1;
    else if (rx_ack) pending_d = 1'b0;
    overrun_d = overrun_q | (complete & pending_q & ~rx_ack);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_overrun = overrun_q;
`endif

endmodule

// File: tb/tb_rx_shift_register.sv
// Directed and randomized bench for rx_shift_register against a bit-placement reference model.
module tb_rx_shift_register;

  logic         clk = 1'b0;
  logic         reset, go_busy, sample_en, miso, lsb, rx_ack;
  logic [6:0]   char_len;
  logic [127:0] rx_data;
  logic         rx_valid, rx_busy;
  logic         rx_overrun;

  int nchecks = 0;
  int nerrs   = 0;

  logic [127:0] prev_word;
  bit           m_pending, m_overrun;

  always #5 clk = ~clk;

  rx_shift_register #(.MAX_LEN(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .go_busy   (go_busy),
    .sample_en (sample_en),
    .miso      (miso),
    .lsb       (lsb),
    .char_len  (char_len),
    .rx_data   (rx_data),
`ifdef SPI_RX_OVERRUN_EN
    .rx_ack    (rx_ack),
    .rx_overrun(rx_overrun),
`endif
    .rx_valid  (rx_valid),
    .rx_busy   (rx_busy)
  );

`ifndef SPI_RX_OVERRUN_EN
  assign rx_overrun = 1'b0;
`endif

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bit i of bv is the i-th bit on the wire; place it where the word format says it belongs
  function automatic logic [127:0] exp_word(input logic [127:0] bv, input int len, input logic l);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < len; i++) begin
      if (l) r[i] = bv[i];
      else   r[len-1-i] = bv[i];
    end
    return r;
  endfunction

  task automatic run_word(input logic [6:0] cl, input logic l, input logic [127:0] bv,
                          input int abort_at, input int maxgap, input bit ack_last);
    int len;
    logic [127:0] exp;
    len = (cl == 0) ? 128 : int'(cl);
    exp = exp_word(bv, len, l);
    go_busy = 1'b1; char_len = cl; lsb = l;
    tick();
    chk("busy_start", {127'b0, rx_busy}, 128'd1);
    char_len = 7'($urandom); lsb = 1'($urandom);
    for (int i = 0; i < len; i++) begin
      if (i == abort_at) break;
      repeat ($urandom_range(maxgap, 0)) tick();
      sample_en = 1'b1; miso = bv[i];
      if (i == len - 1 && ack_last) rx_ack = 1'b1;
      tick();
      sample_en = 1'b0; rx_ack = 1'b0; miso = 1'($urandom);
      if (i < len - 1) chk("valid_early", {127'b0, rx_valid}, 128'd0);
    end
    if (abort_at >= 0 && abort_at < len) begin
      go_busy = 1'b0;
      tick();
      chk("abort_busy", {127'b0, rx_busy}, 128'd0);
      chk("abort_valid", {127'b0, rx_valid}, 128'd0);
      tick();
      chk("abort_data", rx_data, prev_word);
    end else begin
      chk("valid_pulse", {127'b0, rx_valid}, 128'd1);
      chk("word", rx_data, exp);
      chk("busy_done", {127'b0, rx_busy}, 128'd0);
      prev_word = exp;
      if (m_pending && !ack_last) m_overrun = 1'b1;
      m_pending = 1'b1;
      repeat ($urandom_range(3, 1)) tick();
      chk("valid_once", {127'b0, rx_valid}, 128'd0);
      chk("no_restart", {127'b0, rx_busy}, 128'd0);
      go_busy = 1'b0;
      tick();
      chk("data_hold", rx_data, prev_word);
`ifdef SPI_RX_OVERRUN_EN
      chk("overrun", {127'b0, rx_overrun}, {127'b0, m_overrun});
`endif
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    prev_word = '0; m_pending = 1'b0; m_overrun = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] bv;
    int           len;
    int           ab;
    reset = 1'b1; go_busy = 1'b0; sample_en = 1'b0; miso = 1'b0;
    lsb = 1'b0; rx_ack = 1'b0; char_len = '0;
    prev_word = '0; m_pending = 1'b0; m_overrun = 1'b0;
    #12;
    chk("reset_data", rx_data, 128'd0);
    chk("reset_valid", {127'b0, rx_valid}, 128'd0);
    chk("reset_busy", {127'b0, rx_busy}, 128'd0);
    chk("reset_overrun", {127'b0, rx_overrun}, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // 1,0,1,0,0,1,0,1 reads as A5 in either bit order
    bv = 128'b1010_0101;
    run_word(7'd8, 1'b0, bv, -1, 0, 1'b0);
    chk("t1_a5", rx_data, 128'hA5);
    run_word(7'd8, 1'b1, bv, -1, 0, 1'b0);
    chk("t2_a5", rx_data, 128'hA5);
    run_word(7'd8, 1'b1, bv, -1, 5, 1'b0);
    chk("t2_gaps_a5", rx_data, 128'hA5);

    for (int i = 0; i < 128; i++) bv[i] = (i % 2 == 0);
    run_word(7'd0, 1'b0, bv, -1, 1, 1'b0);
    chk("t3_full", rx_data, {32{4'hA}});
    bv = '1;
    run_word(7'd33, 1'b0, bv, -1, 1, 1'b0);
    chk("t3_len33", rx_data, 128'h1_FFFF_FFFF);

    bv = 128'h3C;
    run_word(7'd8, 1'b0, bv, 5, 1, 1'b0);
    chk("t4_kept", rx_data, 128'h1_FFFF_FFFF);
    run_word(7'd8, 1'b0, bv, -1, 1, 1'b0);
    chk("t4_next", rx_data, 128'h3C);

    // abort coinciding with final strobe: no word delivered
    go_busy = 1'b1; char_len = 7'd4; lsb = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      sample_en = 1'b1; miso = 1'b1;
      tick();
    end
    go_busy = 1'b0;
    tick();
    sample_en = 1'b0;
    chk("abort_final_valid", {127'b0, rx_valid}, 128'd0);
    chk("abort_final_busy", {127'b0, rx_busy}, 128'd0);
    chk("abort_final_data", rx_data, 128'h3C);
    tick();

    // asynchronous reset between edges while shifting
    go_busy = 1'b1; char_len = 7'd16;
    tick();
    repeat (5) begin
      sample_en = 1'b1; miso = 1'b1;
      tick();
    end
    sample_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_data", rx_data, 128'd0);
    chk("async_rst_valid", {127'b0, rx_valid}, 128'd0);
    chk("async_rst_busy", {127'b0, rx_busy}, 128'd0);
    go_busy = 1'b0;
    #2;
    reset = 1'b0;
    prev_word = '0; m_pending = 1'b0; m_overrun = 1'b0;
    tick();
    chk("post_rst_idle", {127'b0, rx_busy}, 128'd0);

    for (int w = 0; w < 16; w++) begin
      logic [6:0] cl;
      cl = 7'($urandom);
      len = (cl == 0) ? 128 : int'(cl);
      bv = {$urandom, $urandom, $urandom, $urandom};
      ab = ($urandom_range(3, 0) == 0) ? int'($urandom_range(len - 1, 0)) : -1;
      run_word(cl, 1'($urandom), bv, ab, 2, 1'($urandom));
    end

`ifdef SPI_RX_OVERRUN_EN
    do_reset();
    run_word(7'd8, 1'b0, 128'h11, -1, 0, 1'b0);
    run_word(7'd8, 1'b0, 128'h22, -1, 0, 1'b0);
    chk("ovr_set", {127'b0, rx_overrun}, 128'd1);
    chk("ovr_data", rx_data, 128'h44);
    do_reset();
    run_word(7'd8, 1'b0, 128'h11, -1, 0, 1'b0);
    run_word(7'd8, 1'b0, 128'h22, -1, 0, 1'b1);
    chk("ovr_acked", {127'b0, rx_overrun}, 128'd0);
    run_word(7'd8, 1'b0, 128'h33, -1, 0, 1'b0);
    chk("ovr_pending_kept", {127'b0, rx_overrun}, 128'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
